// File: rtl/color_box_tracker.sv
// Streaming colour classifier: adds one cycle of delay to the pixel stream and tracks the
// bounding box of threshold-matching pixels. It can draw the previous frame's box into the stream.
module color_box_tracker #(
    parameter int unsigned           DATA_WIDTH = 10,
    parameter int unsigned           X_WIDTH    = 11,
    parameter int unsigned           Y_WIDTH    = 11,
    parameter int unsigned           H_ACT      = 640,
    parameter int unsigned           V_ACT      = 480,
    parameter int unsigned           CNT_WIDTH  = 19,
    parameter int unsigned           MIN_PIXELS = 64,
    parameter logic [DATA_WIDTH-1:0] BOX_R      = '0,
    parameter logic [DATA_WIDTH-1:0] BOX_G      = '1,
    parameter logic [DATA_WIDTH-1:0] BOX_B      = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [X_WIDTH-1:0]    in_x,
    input  logic [Y_WIDTH-1:0]    in_y,
    input  logic [DATA_WIDTH-1:0] in_r,
    input  logic [DATA_WIDTH-1:0] in_g,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [DATA_WIDTH-1:0] thr_r_min,
    input  logic [DATA_WIDTH-1:0] thr_g_max,
    input  logic [DATA_WIDTH-1:0] thr_b_max,
    input  logic                  overlay_en,
    output logic                  out_valid,
    output logic [X_WIDTH-1:0]    out_x,
    output logic [Y_WIDTH-1:0]    out_y,
    output logic [DATA_WIDTH-1:0] out_r,
    output logic [DATA_WIDTH-1:0] out_g,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic                  frame_done,
    output logic                  obj_found,
    output logic [X_WIDTH-1:0]    box_x_min,
    output logic [X_WIDTH-1:0]    box_x_max,
    output logic [Y_WIDTH-1:0]    box_y_min,
    output logic [Y_WIDTH-1:0]    box_y_max,
    output logic [CNT_WIDTH-1:0]  match_count
);

    // Widened by one bit so an active size equal to 2^WIDTH still compares correctly.
    localparam logic [X_WIDTH:0]     H_ACT_EXT  = (X_WIDTH + 1)'(H_ACT);
    localparam logic [Y_WIDTH:0]     V_ACT_EXT  = (Y_WIDTH + 1)'(V_ACT);
    localparam logic [X_WIDTH-1:0]   X_LAST     = X_WIDTH'(H_ACT - 1);
    localparam logic [Y_WIDTH-1:0]   Y_LAST     = Y_WIDTH'(V_ACT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [CNT_WIDTH:0]   MIN_EXT    = (CNT_WIDTH + 1)'(MIN_PIXELS);

    // Pixel classification
    logic active;
    logic match;
    logic end_of_frame;

    always_comb begin
        active       = in_valid && ({1'b0, in_x} < H_ACT_EXT) && ({1'b0, in_y} < V_ACT_EXT);
        match        = active && (in_r >= thr_r_min) && (in_g <= thr_g_max) && (in_b <= thr_b_max);
        end_of_frame = active && (in_x == X_LAST) && (in_y == Y_LAST);
    end

    // Accumulators
    logic [X_WIDTH-1:0]   acc_x_min_q, acc_x_min_d;
    logic [X_WIDTH-1:0]   acc_x_max_q, acc_x_max_d;
    logic [Y_WIDTH-1:0]   acc_y_min_q, acc_y_min_d;
    logic [Y_WIDTH-1:0]   acc_y_max_q, acc_y_max_d;
    logic [CNT_WIDTH-1:0] acc_cnt_q,   acc_cnt_d;

    // Frame totals that include the current pixel
    logic [X_WIDTH-1:0]   fin_x_min, fin_x_max;
    logic [Y_WIDTH-1:0]   fin_y_min, fin_y_max;
    logic [CNT_WIDTH-1:0] fin_cnt;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        fin_x_min = acc_x_min_q;
        fin_x_max = acc_x_max_q;
        fin_y_min = acc_y_min_q;
        fin_y_max = acc_y_max_q;
        fin_cnt   = acc_cnt_q;
        if (match) begin
            if (in_x < acc_x_min_q) fin_x_min = in_x;
            if (in_x > acc_x_max_q) fin_x_max = in_x;
            if (in_y < acc_y_min_q) fin_y_min = in_y;
            if (in_y > acc_y_max_q) fin_y_max = in_y;
            if (acc_cnt_q != CNT_MAX) fin_cnt = acc_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        acc_x_min_d = fin_x_min;
        acc_x_max_d = fin_x_max;
        acc_y_min_d = fin_y_min;
        acc_y_max_d = fin_y_max;
        acc_cnt_d   = fin_cnt;
        if (end_of_frame) begin
            acc_x_min_d = '1;
            acc_x_max_d = '0;
            acc_y_min_d = '1;
            acc_y_max_d = '0;
            acc_cnt_d   = '0;
        end
    end

    // Published per-frame results
    logic                  frame_done_q,  frame_done_d;
    logic                  obj_found_q,   obj_found_d;
    logic [X_WIDTH-1:0]    box_x_min_q,   box_x_min_d;
    logic [X_WIDTH-1:0]    box_x_max_q,   box_x_max_d;
    logic [Y_WIDTH-1:0]    box_y_min_q,   box_y_min_d;
    logic [Y_WIDTH-1:0]    box_y_max_q,   box_y_max_d;
    logic [CNT_WIDTH-1:0]  match_count_q, match_count_d;

    always_comb begin
        frame_done_d  = end_of_frame;
        obj_found_d   = obj_found_q;
        box_x_min_d   = box_x_min_q;
        box_x_max_d   = box_x_max_q;
        box_y_min_d   = box_y_min_q;
        box_y_max_d   = box_y_max_q;
        match_count_d = match_count_q;
        if (end_of_frame) begin
            match_count_d = fin_cnt;
            if ({1'b0, fin_cnt} >= MIN_EXT) begin
                obj_found_d = 1'b1;
                box_x_min_d = fin_x_min;
                box_x_max_d = fin_x_max;
                box_y_min_d = fin_y_min;
                box_y_max_d = fin_y_max;
            end else begin
                obj_found_d = 1'b0;
                box_x_min_d = '0;
                box_x_max_d = '0;
                box_y_min_d = '0;
                box_y_max_d = '0;
            end
        end
    end

    // Overlay decision always uses the box published before this edge
    logic on_col;
    logic on_row;
    logic draw_box;

    always_comb begin
        on_col   = ((in_x == box_x_min_q) || (in_x == box_x_max_q))
                   && (in_y >= box_y_min_q) && (in_y <= box_y_max_q);
        on_row   = ((in_y == box_y_min_q) || (in_y == box_y_max_q))
                   && (in_x >= box_x_min_q) && (in_x <= box_x_max_q);
        draw_box = overlay_en && obj_found_q && active && (on_col || on_row);
    end

    // Output pipeline stage
    logic                  out_valid_q, out_valid_d;
    logic [X_WIDTH-1:0]    out_x_q,     out_x_d;
    logic [Y_WIDTH-1:0]    out_y_q,     out_y_d;
    logic [DATA_WIDTH-1:0] out_r_q,     out_r_d;
    logic [DATA_WIDTH-1:0] out_g_q,     out_g_d;
    logic [DATA_WIDTH-1:0] out_b_q,     out_b_d;

    always_comb begin
        out_valid_d = in_valid;
        out_x_d     = in_x;
        out_y_d     = in_y;
        out_r_d     = draw_box ? BOX_R : in_r;
        out_g_d     = draw_box ? BOX_G : in_g;
        out_b_d     = draw_box ? BOX_B : in_b;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_x_min_q   <= '1;
            acc_x_max_q   <= '0;
            acc_y_min_q   <= '1;
            acc_y_max_q   <= '0;
            acc_cnt_q     <= '0;
            frame_done_q  <= 1'b0;
            obj_found_q   <= 1'b0;
            box_x_min_q   <= '0;
            box_x_max_q   <= '0;
            box_y_min_q   <= '0;
            box_y_max_q   <= '0;
            match_count_q <= '0;
            out_valid_q   <= 1'b0;
            out_x_q       <= '0;
            out_y_q       <= '0;
            out_r_q       <= '0;
            out_g_q       <= '0;
            out_b_q       <= '0;
        end else begin
            acc_x_min_q   <= acc_x_min_d;
            acc_x_max_q   <= acc_x_max_d;
            acc_y_min_q   <= acc_y_min_d;
            acc_y_max_q   <= acc_y_max_d;
            acc_cnt_q     <= acc_cnt_d;
            frame_done_q  <= frame_done_d;
            obj_found_q   <= obj_found_d;
            box_x_min_q   <= box_x_min_d;
            box_x_max_q   <= box_x_max_d;
            box_y_min_q   <= box_y_min_d;
            box_y_max_q   <= box_y_max_d;
            match_count_q <= match_count_d;
            out_valid_q   <= out_valid_d;
            out_x_q       <= out_x_d;
            out_y_q       <= out_y_d;
            out_r_q       <= out_r_d;
            out_g_q       <= out_g_d;
            out_b_q       <= out_b_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_x       = out_x_q;
    assign out_y       = out_y_q;
    assign out_r       = out_r_q;
    assign out_g       = out_g_q;
    assign out_b       = out_b_q;
    assign frame_done  = frame_done_q;
    assign obj_found   = obj_found_q;
    assign box_x_min   = box_x_min_q;
    assign box_x_max   = box_x_max_q;
    assign box_y_min   = box_y_min_q;
    assign box_y_max   = box_y_max_q;
    assign match_count = match_count_q;

endmodule
